mem_lsu: RTL and testbench

//  MEM-stage load/store unit of the 5-stage RV32I pipeline; consumer of the EX-stage aluop/mem_addr/rs2 outputs.

---
 rtl/mem_lsu.sv | 197 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data bus master with byte lanes, load extension and stall request.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_CHK_EN.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] rs2_i,
  input  logic        wreg_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  output logic        wreg_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        stallreq_mem_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam logic [4:0] ALUOP_LB  = 5'd16;
  localparam logic [4:0] ALUOP_LH  = 5'd17;
  localparam logic [4:0] ALUOP_LW  = 5'd18;
  localparam logic [4:0] ALUOP_LBU = 5'd19;
  localparam logic [4:0] ALUOP_LHU = 5'd20;
  localparam logic [4:0] ALUOP_SB  = 5'd21;
  localparam logic [4:0] ALUOP_SH  = 5'd22;
  localparam logic [4:0] ALUOP_SW  = 5'd23;

  // TIMEOUT_CYCLES == 0 disables the abort entirely.
  localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_req, r_we, r_bus_err;
  logic [31:0] r_addr, r_wdata, r_load;
  logic [3:0]  r_be;
  logic [4:0]  r_op;
  logic [1:0]  r_off;
  logic [15:0] r_cnt;
  logic        w_memop, w_misalign, w_timeout;

  function automatic logic f_is_memop(input logic [4:0] op);
    return (op >= ALUOP_LB) && (op <= ALUOP_SW);
  endfunction

  function automatic logic f_is_store(input logic [4:0] op);
    return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
  endfunction

  function automatic logic [3:0] f_lane_be(input logic [4:0] op, input logic [1:0] a);
    case (op)
      ALUOP_SB: f_lane_be = 4'b0001 << a;
      ALUOP_SH: f_lane_be = a[1] ? 4'b1100 : 4'b0011;
      default:  f_lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_lane_wdata(input logic [4:0] op, input logic [31:0] d);
    case (op)
      ALUOP_SB: f_lane_wdata = {4{d[7:0]}};
      ALUOP_SH: f_lane_wdata = {2{d[15:0]}};
      ALUOP_SW: f_lane_wdata = d;
      default:  f_lane_wdata = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [4:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      ALUOP_LB:  f_load_ext = {{24{b[7]}}, b};
      ALUOP_LBU: f_load_ext = {24'd0, b};
      ALUOP_LH:  f_load_ext = {{16{h[15]}}, h};
      ALUOP_LHU: f_load_ext = {16'd0, h};
      ALUOP_LW:  f_load_ext = d;
      default:   f_load_ext = 32'd0;
    endcase
  endfunction

  assign w_memop   = f_is_memop(aluop_i);
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    w_misalign = 1'b0;
    case (aluop_i)
      ALUOP_LH, ALUOP_LHU, ALUOP_SH: w_misalign = mem_addr_i[0];
      ALUOP_LW, ALUOP_SW:            w_misalign = |mem_addr_i[1:0];
      default:                       w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    stallreq_mem_o = 1'b0;
    misalign_o     = 1'b0;
    wreg_o         = wreg_i;
    rd_addr_o      = rd_addr_i;
    rd_data_o      = rd_data_i;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          if (w_misalign) begin
            misalign_o = 1'b1;
            wreg_o     = 1'b0;
          end else begin
            stallreq_mem_o = 1'b1;
            w_state_nxt    = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stallreq_mem_o = 1'b1;
        if (dbus_ack_i || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        rd_data_o   = r_load;
        wreg_o      = wreg_i & ~r_we;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A stalled instruction must reach MEM/WB as a bubble.
    if (stallreq_mem_o) wreg_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_be      <= 4'd0;
      r_op      <= 5'd0;
      r_off     <= 2'd0;
      r_cnt     <= 16'd0;
      r_load    <= 32'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_BUSY) begin
            r_req   <= 1'b1;
            r_we    <= f_is_store(aluop_i);
            r_addr  <= {mem_addr_i[31:2], 2'b00};
            r_be    <= f_lane_be(aluop_i, mem_addr_i[1:0]);
            r_wdata <= f_lane_wdata(aluop_i, rs2_i);
            r_op    <= aluop_i;
            r_off   <= mem_addr_i[1:0];
            r_cnt   <= 16'd0;
          end
        end
        S_BUSY: begin
          if (dbus_ack_i) begin
            r_req  <= 1'b0;
            r_load <= f_load_ext(r_op, r_off, dbus_rdata_i);
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_load    <= 32'd0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbus_req_o   = r_req;
  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_be_o    = r_be;
  assign dbus_wdata_o = r_wdata;
  assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: per-scenario tasks, expected writeback results queued at issue and popped at completion.
// Honours LSU_MISALIGN_CHK_EN the same way the design does.
module tb_mem_lsu;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_LB  = 5'd16;
  localparam logic [4:0] OP_LH  = 5'd17;
  localparam logic [4:0] OP_LW  = 5'd18;
  localparam logic [4:0] OP_LBU = 5'd19;
  localparam logic [4:0] OP_LHU = 5'd20;
  localparam logic [4:0] OP_SB  = 5'd21;
  localparam logic [4:0] OP_SH  = 5'd22;
  localparam logic [4:0] OP_SW  = 5'd23;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  aluop_i = OP_ADD;
  logic [31:0] mem_addr_i = '0, rs2_i = '0, rd_data_i = '0, dbus_rdata_i = '0;
  logic        wreg_i = 1'b0, dbus_ack_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        wreg_o, stallreq_mem_o, dbus_req_o, dbus_we_o, bus_err_o, misalign_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        wreg;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          req_cyc;
    int          stall_cyc;
    int          wreg_in_stall;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] data;
    logic        wreg;
    logic        err;
    logic        done;
  } obs_t;

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .rs2_i(rs2_i),
    .wreg_i(wreg_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .wreg_o(wreg_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .stallreq_mem_o(stallreq_mem_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Drives one memory instruction and answers the bus; ack_at = BUSY cycle index to ack (-1: never).
  task automatic do_access(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int ack_at, output obs_t o);
    int busy_idx = 0;
    o = '{default: '0};
    @(negedge clk);
    aluop_i = op; mem_addr_i = addr; rs2_i = rs2; wreg_i = 1'b1; rd_addr_i = 5'd9;
    rd_data_i = 32'h5555_5555;
    for (int c = 0; c < 40 && !o.done; c++) begin
      #1;
      if (stallreq_mem_o) begin
        o.stall_cyc++;
        if (wreg_o) o.wreg_in_stall++;
      end else begin
        o.done = 1'b1; o.data = rd_data_o; o.wreg = wreg_o; o.err = bus_err_o;
      end
      if (dbus_req_o) begin
        if (o.req_cyc == 0) begin
          o.be = dbus_be_o; o.addr = dbus_addr_o; o.wdata = dbus_wdata_o; o.we = dbus_we_o;
        end
        o.req_cyc++;
        if (busy_idx == ack_at) begin dbus_ack_i = 1'b1; dbus_rdata_i = rdata; end
        busy_idx++;
      end
      if (o.done) begin
        aluop_i = OP_ADD; mem_addr_i = '0;
      end else begin
        @(negedge clk);
        dbus_ack_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; aluop_i = OP_ADD; wreg_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (dbus_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b want=0", dbus_req_o); end
    n_total++; if (dbus_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", dbus_we_o); end
    n_total++; if ({dbus_addr_o, dbus_wdata_o, dbus_be_o} !== 68'd0) begin n_bad++;
      $display("FAIL reset_bus addr=%h wdata=%h be=%b want all 0", dbus_addr_o, dbus_wdata_o, dbus_be_o); end
    n_total++; if ({bus_err_o, misalign_o, stallreq_mem_o} !== 3'b000) begin n_bad++;
      $display("FAIL reset_flags err/mis/stall=%b%b%b want=000", bus_err_o, misalign_o, stallreq_mem_o); end
  endtask

  task automatic test_store_word;
    obs_t o; exp_t e;
    exp_q.push_back('{data: 32'hx, wreg: 1'b0});
    do_access(OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, o);
    e = exp_q.pop_front();
    n_total++; if (o.req_cyc !== 1) begin n_bad++; $display("FAIL sw_req_cycles got=%0d want=1", o.req_cyc); end
    n_total++; if (o.stall_cyc !== 2) begin n_bad++; $display("FAIL sw_stall_cycles got=%0d want=2", o.stall_cyc); end
    n_total++; if ({o.we, o.be, o.addr} !== {1'b1, 4'b1111, 32'h100}) begin n_bad++;
      $display("FAIL sw_bus we=%b be=%b addr=%h want 1 1111 00000100", o.we, o.be, o.addr); end
    n_total++; if (o.wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata got=%h want=deadbeef", o.wdata); end
    n_total++; if (o.wreg !== e.wreg) begin n_bad++; $display("FAIL sw_wreg got=%b want=%b", o.wreg, e.wreg); end
  endtask

  task automatic test_loads;
    obs_t o; exp_t e;
    logic [4:0]  ops[6]   = '{OP_LB, OP_LHU, OP_LH, OP_LBU, OP_LW, OP_LB};
    logic [31:0] adrs[6]  = '{32'h203, 32'h202, 32'h000, 32'h001, 32'h104, 32'h002};
    logic [31:0] rdat[6]  = '{32'h80FF_0000, 32'h8001_1234, 32'h1234_F00D, 32'h0000_9A00,
                              32'hCAFE_F00D, 32'h0055_0000};
    logic [31:0] want[6]  = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_F00D, 32'h0000_009A,
                              32'hCAFE_F00D, 32'h0000_0055};
    int          acks[6]  = '{2, 0, 1, 0, 3, 0};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{data: want[i], wreg: 1'b1});
      do_access(ops[i], adrs[i], 32'h0, rdat[i], acks[i], o);
      e = exp_q.pop_front();
      n_total++; if (o.data !== e.data) begin n_bad++;
        $display("FAIL load%0d_data got=%h want=%h", i, o.data, e.data); end
      n_total++; if ({o.wreg, o.err, o.we, o.be} !== {e.wreg, 1'b0, 1'b0, 4'b1111}) begin n_bad++;
        $display("FAIL load%0d_ctl wreg/err/we/be=%b%b%b%b want=1001111", i, o.wreg, o.err, o.we, o.be); end
      n_total++; if ((o.req_cyc !== acks[i] + 1) || (o.wreg_in_stall !== 0)) begin n_bad++;
        $display("FAIL load%0d_timing req=%0d want=%0d wreg_in_stall=%0d want=0", i, o.req_cyc,
                 acks[i] + 1, o.wreg_in_stall); end
    end
    n_total++; if (o.addr !== 32'h0) begin n_bad++; $display("FAIL load_word_addr got=%h want=0", o.addr); end
  endtask

  task automatic test_sub_stores;
    obs_t o;
    do_access(OP_SB, 32'h1, 32'h0000_00AB, 32'h0, 0, o);
    n_total++; if ({o.be, o.wdata, o.wreg} !== {4'b0010, 32'hABABABAB, 1'b0}) begin n_bad++;
      $display("FAIL sb_lane be=%b wdata=%h wreg=%b want 0010 abababab 0", o.be, o.wdata, o.wreg); end
    do_access(OP_SH, 32'h102, 32'h1234_BEEF, 32'h0, 1, o);
    n_total++; if ({o.be, o.wdata, o.addr} !== {4'b1100, 32'hBEEFBEEF, 32'h100}) begin n_bad++;
      $display("FAIL sh_lane be=%b wdata=%h addr=%h want 1100 beefbeef 00000100", o.be, o.wdata, o.addr); end
  endtask

  task automatic test_timeout;
    obs_t o; exp_t e;
    exp_q.push_back('{data: 32'h0, wreg: 1'b1});
    do_access(OP_LW, 32'h300, 32'h0, 32'hFFFF_FFFF, -1, o);
    e = exp_q.pop_front();
    n_total++; if ((o.done !== 1'b1) || (o.req_cyc !== 4) || (o.stall_cyc !== 5)) begin n_bad++;
      $display("FAIL timeout_cycles done=%b req=%0d stall=%0d want 1 4 5", o.done, o.req_cyc, o.stall_cyc); end
    n_total++; if ({o.err, o.data} !== {1'b1, e.data}) begin n_bad++;
      $display("FAIL timeout_result err=%b data=%h want 1 %h", o.err, o.data, e.data); end
    @(negedge clk); #1;
    n_total++; if ({bus_err_o, dbus_req_o} !== 2'b00) begin n_bad++;
      $display("FAIL timeout_pulse err/req=%b%b want=00", bus_err_o, dbus_req_o); end
  endtask

  task automatic test_rst_busy;
    @(negedge clk);
    aluop_i = OP_LW; mem_addr_i = 32'h400; wreg_i = 1'b1;
    @(negedge clk); #1;
    n_total++; if (dbus_req_o !== 1'b1) begin n_bad++; $display("FAIL rst_busy_req_start got=%b want=1", dbus_req_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; aluop_i = OP_ADD; mem_addr_i = '0; rd_data_i = 32'd7; rd_addr_i = 5'd3;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
    #1;
    n_total++; if ({dbus_req_o, stallreq_mem_o} !== 2'b00) begin n_bad++;
      $display("FAIL rst_busy_drop req/stall=%b%b want=00", dbus_req_o, stallreq_mem_o); end
    n_total++; if ({wreg_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd3, 32'd7}) begin n_bad++;
      $display("FAIL rst_busy_pass wreg=%b rd=%0d data=%h want 1 3 00000007", wreg_o, rd_addr_o, rd_data_o); end
    @(negedge clk);
    dbus_ack_i = 1'b0;
    #1;
    n_total++; if ({dbus_req_o, stallreq_mem_o, rd_data_o} !== {2'b00, 32'd7}) begin n_bad++;
      $display("FAIL rst_late_ack req/stall=%b%b data=%h want 00 00000007", dbus_req_o, stallreq_mem_o, rd_data_o); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    aluop_i = OP_ADD; wreg_i = 1'b1; rd_data_i = 32'h0BAD_CAFE; rd_addr_i = 5'd31;
    #1;
    n_total++; if ({wreg_o, rd_addr_o, rd_data_o, stallreq_mem_o} !== {1'b1, 5'd31, 32'h0BADCAFE, 1'b0}) begin
      n_bad++; $display("FAIL pass_a wreg=%b rd=%0d data=%h stall=%b want 1 31 0badcafe 0",
                        wreg_o, rd_addr_o, rd_data_o, stallreq_mem_o); end
    wreg_i = 1'b0; rd_data_i = 32'h1;
    #1;
    n_total++; if ({wreg_o, rd_data_o} !== {1'b0, 32'h1}) begin n_bad++;
      $display("FAIL pass_b wreg=%b data=%h want 0 00000001", wreg_o, rd_data_o); end
  endtask

  task automatic test_misalign;
`ifdef LSU_MISALIGN_CHK_EN
    @(negedge clk);
    aluop_i = OP_LW; mem_addr_i = 32'h102; wreg_i = 1'b1;
    #1;
    n_total++; if ({misalign_o, stallreq_mem_o, wreg_o} !== 3'b100) begin n_bad++;
      $display("FAIL misalign_flag mis/stall/wreg=%b%b%b want=100", misalign_o, stallreq_mem_o, wreg_o); end
    @(negedge clk);
    aluop_i = OP_ADD; mem_addr_i = '0;
    #1;
    n_total++; if ({dbus_req_o, misalign_o} !== 2'b00) begin n_bad++;
      $display("FAIL misalign_nobus req/mis=%b%b want=00", dbus_req_o, misalign_o); end
`else
    obs_t o;
    do_access(OP_LW, 32'h102, 32'h0, 32'h7654_3210, 0, o);
    n_total++; if ({o.addr, o.data, o.req_cyc} !== {32'h100, 32'h76543210, 32'd1}) begin n_bad++;
      $display("FAIL misalign_off addr=%h data=%h req=%0d want 00000100 76543210 1", o.addr, o.data, o.req_cyc); end
    n_total++; if (misalign_o !== 1'b0) begin n_bad++; $display("FAIL misalign_tied got=%b want=0", misalign_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_sub_stores();
    test_timeout();
    test_rst_busy();
    test_back_to_back();
    test_misalign();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
